// File: rtl/parser_pkg.sv
// Shared EtherType constants, header offsets and byte-order helper for the
// Ethernet header parser stages.
package parser_pkg;

    localparam logic [15:0] ETYPE_VLAN = 16'h8100;
    localparam logic [15:0] ETYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETYPE_IP4  = 16'h0800;

    localparam int unsigned ETYPE_OFFSET       = 32'd12;
    localparam int unsigned TCI_OFFSET         = 32'd14;
    localparam int unsigned INNER_ETYPE_OFFSET = 32'd16;

    // The first wire byte lands in the low lane bits; header fields are big-endian.
    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/etype_vlan_parser_if.sv
// AXI-Stream bundle shared by the parser stages; master drives payload, slave drives tready.
interface etype_vlan_parser_if #(
    parameter int DATA_W = 32'd64,
    parameter int ID_W   = 32'd4,
    parameter int DEST_W = 32'd4
);

    logic [DATA_W-1:0]   tdata;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata, tid, tdest, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tid, tdest, tkeep, tlast, tvalid,
        output tready
    );

endinterface

// File: rtl/parser_lane_extract.sv
// Pulls a 16-bit big-endian header field out of the beat that carries it,
// flagging the accepted beat whose byte window contains the field offset.
module parser_lane_extract
    import parser_pkg::*;
#(
    parameter int BUS_WIDTH = 32'd64,
    parameter int POS_BITS  = 32'd11
) (
    input  logic [BUS_WIDTH-1:0] i_tdata,
    input  logic [POS_BITS-1:0]  i_cur_pos,
    input  logic [POS_BITS-1:0]  i_offset,
    input  logic                 i_beat,
    output logic [15:0]          o_data,
    output logic                 o_present
);

    localparam int NB        = BUS_WIDTH / 32'd8;
    localparam int LANE_BITS = $clog2(NB);

    logic [LANE_BITS-1:0] w_lane;

    // Offsets are even and the bus holds at least two bytes, so a field never straddles beats.
    assign w_lane    = i_offset[LANE_BITS-1:0];
    assign o_data    = swap16(16'(i_tdata >> {w_lane, 3'b000}));
    assign o_present = i_beat && ((i_offset >> LANE_BITS) == (i_cur_pos >> LANE_BITS));

endmodule

// File: rtl/etype_vlan_parser.sv
// Pass-through AXIS parser stage: tracks byte position, detects an 802.1Q tag,
// decodes the effective EtherType and filters the route mask with a per-ID VLAN CAM.
module etype_vlan_parser
    import parser_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH      = 32'd64,
    parameter int AXIS_ID_WIDTH       = 32'd4,
    parameter int AXIS_DEST_WIDTH     = 32'd4,
    parameter int MAX_PACKET_LENGTH   = 32'd1522,
    localparam int NUM_BUS_BYTES      = AXIS_BUS_WIDTH / 32'd8,
    localparam int NUM_AXIS_ID        = 32'd2 ** AXIS_ID_WIDTH,
    localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH + 32'd1)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    etype_vlan_parser_if.slave               axis_in,
    etype_vlan_parser_if.master              axis_out,
    input  logic [NUM_AXIS_ID-1:0]           route_mask_in,
    input  logic [NUM_AXIS_ID-1:0][11:0]     vlan_ids,
    input  logic [NUM_AXIS_ID-1:0]           vlan_must_match,
    output logic [NUM_AXIS_ID-1:0]           route_mask_out,
    output logic                             parsing_done_out,
    output logic [PACKET_LENGTH_CBITS-1:0]   cur_pos_out,
    output logic                             is_tagged_out,
    output logic                             next_is_arp_out,
    output logic                             next_is_ip4_out
);

    localparam int CAP = (MAX_PACKET_LENGTH / NUM_BUS_BYTES) * NUM_BUS_BYTES;
    localparam logic [PACKET_LENGTH_CBITS-1:0] CAP_POS  = PACKET_LENGTH_CBITS'(CAP);
    localparam logic [PACKET_LENGTH_CBITS-1:0] STEP_POS = PACKET_LENGTH_CBITS'(NUM_BUS_BYTES);

    logic [PACKET_LENGTH_CBITS-1:0] r_cur_pos;
    logic                           r_tagged;
    logic                           r_done;
    logic                           r_arp;
    logic                           r_ip4;
    logic [NUM_AXIS_ID-1:0]         r_vlan_mask;

    logic        w_beat;
    logic        w_last;
    logic [15:0] w_etype;
    logic        w_etype_present;
    logic [15:0] w_tci;
    logic        w_tci_present;
    logic [15:0] w_inner;
    logic        w_inner_present;
    logic        w_tagged;
    logic        w_eff_present;
    logic [15:0] w_eff;
    logic        w_done;
    logic        w_arp;
    logic        w_ip4;
    logic        w_untag_hit;
    logic        w_tci_hit;
    logic        w_unused_pcp;
    logic [NUM_AXIS_ID-1:0] w_vlan_mask;

    assign axis_out.tdata  = axis_in.tdata;
    assign axis_out.tid    = axis_in.tid;
    assign axis_out.tdest  = axis_in.tdest;
    assign axis_out.tkeep  = axis_in.tkeep;
    assign axis_out.tlast  = axis_in.tlast;
    assign axis_out.tvalid = axis_in.tvalid;
    assign axis_in.tready  = axis_out.tready;

    assign w_beat = axis_in.tvalid & axis_out.tready;
    assign w_last = w_beat & axis_in.tlast;

    parser_lane_extract #(
        .BUS_WIDTH (AXIS_BUS_WIDTH),
        .POS_BITS  (PACKET_LENGTH_CBITS)
    ) u_outer_etype (
        .i_tdata   (axis_in.tdata),
        .i_cur_pos (r_cur_pos),
        .i_offset  (PACKET_LENGTH_CBITS'(ETYPE_OFFSET)),
        .i_beat    (w_beat),
        .o_data    (w_etype),
        .o_present (w_etype_present)
    );

    parser_lane_extract #(
        .BUS_WIDTH (AXIS_BUS_WIDTH),
        .POS_BITS  (PACKET_LENGTH_CBITS)
    ) u_tci (
        .i_tdata   (axis_in.tdata),
        .i_cur_pos (r_cur_pos),
        .i_offset  (PACKET_LENGTH_CBITS'(TCI_OFFSET)),
        .i_beat    (w_beat),
        .o_data    (w_tci),
        .o_present (w_tci_present)
    );

    parser_lane_extract #(
        .BUS_WIDTH (AXIS_BUS_WIDTH),
        .POS_BITS  (PACKET_LENGTH_CBITS)
    ) u_inner_etype (
        .i_tdata   (axis_in.tdata),
        .i_cur_pos (r_cur_pos),
        .i_offset  (PACKET_LENGTH_CBITS'(INNER_ETYPE_OFFSET)),
        .i_beat    (w_beat),
        .o_data    (w_inner),
        .o_present (w_inner_present)
    );

    // On wide buses the tag and inner EtherType share a beat, so the live tag steers selection.
    assign w_tagged      = r_tagged | (w_etype_present & (w_etype == ETYPE_VLAN));
    assign w_eff_present = w_tagged ? w_inner_present : w_etype_present;
    assign w_eff         = w_tagged ? w_inner : w_etype;
    assign w_done        = r_done | w_eff_present;
    assign w_arp         = w_eff_present ? (w_eff == ETYPE_ARP) : r_arp;
    assign w_ip4         = w_eff_present ? (w_eff == ETYPE_IP4) : r_ip4;

    assign w_untag_hit  = w_etype_present & ~w_tagged;
    assign w_tci_hit    = w_tci_present & w_tagged;
    assign w_unused_pcp = ^w_tci[15:12];

    // VLAN CAM: an enforcing ID drops out on an untagged frame or on a VID mismatch.
    always_comb begin
        w_vlan_mask = r_vlan_mask;
        for (int k = 0; k < NUM_AXIS_ID; k++) begin
            if (vlan_must_match[k] && (w_untag_hit || (w_tci_hit && (w_tci[11:0] != vlan_ids[k])))) begin
                w_vlan_mask[k] = 1'b0;
            end else begin
                w_vlan_mask[k] = r_vlan_mask[k];
            end
        end
    end

    // Byte position and per-packet sticky parse state; a last beat rearms for the next frame.
    always_ff @(posedge aclk) begin
        if (!aresetn || w_last) begin
            r_cur_pos   <= {PACKET_LENGTH_CBITS{1'b0}};
            r_tagged    <= 1'b0;
            r_done      <= 1'b0;
            r_arp       <= 1'b0;
            r_ip4       <= 1'b0;
            r_vlan_mask <= {NUM_AXIS_ID{1'b1}};
        end else if (w_beat) begin
            r_cur_pos   <= (r_cur_pos == CAP_POS) ? CAP_POS : r_cur_pos + STEP_POS;
            r_tagged    <= w_tagged;
            r_done      <= w_done;
            r_arp       <= w_arp;
            r_ip4       <= w_ip4;
            r_vlan_mask <= w_vlan_mask;
        end else begin
            r_cur_pos   <= r_cur_pos;
            r_tagged    <= r_tagged;
            r_done      <= r_done;
            r_arp       <= r_arp;
            r_ip4       <= r_ip4;
            r_vlan_mask <= r_vlan_mask;
        end
    end

    assign route_mask_out   = route_mask_in & w_vlan_mask;
    assign parsing_done_out = w_done;
    assign cur_pos_out      = r_cur_pos;
    assign is_tagged_out    = w_tagged;
    assign next_is_arp_out  = w_arp;
    assign next_is_ip4_out  = w_ip4;

endmodule
